mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
MEM stage of the pipelined CPU. Consumes the EX/MEM pipeline register fields and the store-data forward select from the MEM forwarding unit, then issues byte/half/word loads and stores to a variable-latency data memory over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and owns the MEM/WB pipeline register. Its MEM/WB outputs, including the load result, feed writeback and the forwarding unit.

Parameters:
REG_W, 6, register index width (matches Rt fields in the forwarding path)
DATA_W, 32, datapath and memory word width (fixed at 32; byte enables are 4 bits)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_EX_MEM_alu_out  in  32  effective address, or ALU result for non-memory ops
i_EX_MEM_Rt_data  in  32  store data read in ID/EX
i_EX_MEM_Rt  in  REG_W  store source register index
i_EX_MEM_write_addr  in  REG_W  destination register
i_EX_MEM_reg_write  in  1  instruction writes a register
i_EX_MEM_mem_read  in  1  load
i_EX_MEM_mem_write  in  1  store
i_EX_MEM_size  in  2  0=byte, 1=half, 2=word
i_EX_MEM_unsigned  in  1  zero-extend loads
i_forward  in  1  take store data from o_MEM_WB_wdata instead of i_EX_MEM_Rt_data
o_dmem_req  out  1  access request
o_dmem_we  out  1  write strobe
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  access complete; rdata valid this cycle
i_dmem_rdata  in  32  read word
o_stall  out  1  hold EX/MEM and all earlier stages
o_misalign  out  1  one-cycle pulse on a misaligned access
o_MEM_WB_reg_write  out  1  writeback enable
o_MEM_WB_write_addr  out  REG_W  destination register
o_MEM_WB_mem_read  out  1  MEM/WB holds a load
o_MEM_WB_Rt  out  REG_W  copy of the destination index, for the forwarding unit
o_MEM_WB_wdata  out  32  writeback data (extended load data or ALU result)

Behaviour:
- Reset (async): state IDLE; o_dmem_req/we/be/addr/wdata, o_misalign and all o_MEM_WB_* are 0. o_stall = 0.
- FSM states: IDLE, BUSY.
- IDLE, no memory op: MEM/WB loads the EX/MEM fields on the next edge; wdata = alu_out. Latency is 1 cycle and o_stall = 0.
- IDLE, aligned memory op:
  - o_stall = 1 combinationally.
  - At the edge, register the request: addr, we = mem_write, be, and wdata = (i_forward ? o_MEM_WB_wdata : i_EX_MEM_Rt_data) replicated per size. Also latch size, unsigned, write_addr, reg_write and mem_read.
  - Set o_dmem_req = 1, enter BUSY.
  - MEM/WB loads a bubble: reg_write = 0, mem_read = 0. The forward data is captured before MEM/WB is overwritten.
- BUSY:
  - o_dmem_req and all request fields are held stable until ack.
  - o_stall = !i_dmem_ack. EX/MEM is ignored in this state; upstream holds the same instruction.
  - On the i_dmem_ack edge: MEM/WB loads the latched fields; a load's wdata = extracted/extended rdata, and a store has reg_write = 0. o_dmem_req drops to 0 and the FSM returns to IDLE.
  - Minimum memory-op latency is 2 cycles (ack in the first BUSY cycle). Ack may arrive any number of cycles later.
- Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}.
- Load extraction: select the lane by addr[1:0]. Sign- or zero-extend per unsigned. Word loads ignore the unsigned flag.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0):
  - No request and no stall.
  - o_misalign = 1 for the next cycle only.
  - MEM/WB loads a bubble.
- size = 3 is treated as word.
- mem_read and mem_write both asserted: treated as a store.
- i_dmem_ack while IDLE is ignored, including a stale ack after reset.
- Reset while BUSY: the request is aborted immediately and the FSM returns to IDLE.

Decomposition:
- Package mem_pkg holds the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the FSM state typedef, and the byte-enable constants.
- Sub-module mem_load_align is combinational: inputs rdata, addr[1:0], size, unsigned; output the extended 32-bit load value.

Test Plan:
- ALU op (alu_out=0x1234, reg_write=1, write_addr=5) -> next cycle o_MEM_WB_wdata=0x1234, reg_write=1, write_addr=5, o_stall stays 0.
- lw at addr 0x100, ack after 3 BUSY cycles, rdata=0xDEADBEEF:
  - o_dmem_addr=0x100, be=4'hF, req held 3 cycles, o_stall high for 4 cycles.
  - Then wdata=0xDEADBEEF and reg_write=1.
- lb at 0x103, rdata=0x80FF_FF_FF -> wdata=0xFFFFFF80. lbu at the same address -> 0x00000080. lh at 0x102 with rdata=0x7FFF0000 -> 0x00007FFF.
- Load r8 (wdata=0xCAFEF00D), then sb at 0x201 with i_forward=1:
  - o_dmem_wdata=0x0D0D0D0D, be=4'b0010, we=1.
  - MEM/WB reg_write=0 after ack.
- sw at 0x102 -> o_misalign pulses for 1 cycle, o_dmem_req stays 0, no stall, MEM/WB bubble.
- Assert i_rst mid-BUSY:
  - Outputs zero immediately.
  - An ack arriving after reset release produces no MEM/WB update.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the access-size encodings, the FSM state type, the byte-enable patterns
// and a helper that folds the reserved size code onto a word access.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;

  // Access size encodings carried in EX/MEM
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // FSM state type and encodings
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Byte-enable patterns
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  // The unused size code 3 behaves as a word access
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data lane selection and extension (combinational).
// Ports:
//   i_rdata    : raw 32-bit word returned by data memory
//   i_off      : byte offset of the access, addr[1:0]
//   i_size     : access size (byte/half/word, 3 treated as word)
//   i_unsigned : zero-extend instead of sign-extend (ignored for words)
//   o_data_c   : extended 32-bit load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = 8'(i_rdata >> {i_off, 3'b000});
    half_v   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data_c = i_rdata;
    case (norm_size(i_size))
      SZ_BYTE: o_data_c = i_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: o_data_c = i_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues byte/half/word loads and stores to a
// variable-latency data memory over req/ack, stalls upstream while an access
// is outstanding, and owns the MEM/WB pipeline register.
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_EX_MEM_*             : EX/MEM pipeline register fields
//   i_forward              : store data comes from o_MEM_WB_wdata
//   o_dmem_* / i_dmem_*    : data memory request/response handshake
//   o_stall                : hold EX/MEM and earlier stages (combinational)
//   o_misalign             : one-cycle pulse on a misaligned access
//   o_MEM_WB_*             : MEM/WB pipeline register
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned REG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_EX_MEM_alu_out,
  input  logic [DATA_W-1:0] i_EX_MEM_Rt_data,
  input  logic [REG_W-1:0]  i_EX_MEM_Rt,
  input  logic [REG_W-1:0]  i_EX_MEM_write_addr,
  input  logic              i_EX_MEM_reg_write,
  input  logic              i_EX_MEM_mem_read,
  input  logic              i_EX_MEM_mem_write,
  input  logic [1:0]        i_EX_MEM_size,
  input  logic              i_EX_MEM_unsigned,
  input  logic              i_forward,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic [BE_W-1:0]   o_dmem_be,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_MEM_WB_reg_write,
  output logic [REG_W-1:0]  o_MEM_WB_write_addr,
  output logic              o_MEM_WB_mem_read,
  output logic [REG_W-1:0]  o_MEM_WB_Rt,
  output logic [DATA_W-1:0] o_MEM_WB_wdata
);

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dwdata_q, dwdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                misalign_q, misalign_d;
  logic [1:0]          lat_off_q, lat_off_d;
  logic [1:0]          lat_size_q, lat_size_d;
  logic                lat_unsigned_q, lat_unsigned_d;
  logic [REG_W-1:0]    lat_waddr_q, lat_waddr_d;
  logic                lat_reg_write_q, lat_reg_write_d;
  logic                lat_mem_read_q, lat_mem_read_d;
  logic                wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]    wb_waddr_q, wb_waddr_d;
  logic                wb_mem_read_q, wb_mem_read_d;
  logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;

  logic [1:0]          size_n;
  logic [1:0]          off;
  logic                is_mem;
  logic                misal;
  logic [DATA_W-1:0]   st_data;
  logic [DATA_W-1:0]   st_rep;
  logic [BE_W-1:0]     be_calc;
  logic [DATA_W-1:0]   load_val;
  logic                stall_c;

  // Store source index is consumed by the forwarding unit, not by this stage
  logic                unused_rt;
  assign unused_rt = ^i_EX_MEM_Rt;

  mem_load_align u_load_align (
    .i_rdata    (i_dmem_rdata),
    .i_off      (lat_off_q),
    .i_size     (lat_size_q),
    .i_unsigned (lat_unsigned_q),
    .o_data_c   (load_val)
  );

  // Decode of the incoming EX/MEM access
  always_comb begin
    size_n  = norm_size(i_EX_MEM_size);
    off     = i_EX_MEM_alu_out[1:0];
    is_mem  = i_EX_MEM_mem_read | i_EX_MEM_mem_write;
    misal   = is_mem & (((size_n == SZ_HALF) & off[0]) |
                        ((size_n == SZ_WORD) & (off != 2'b00)));
    st_data = i_forward ? wb_wdata_q : i_EX_MEM_Rt_data;
    st_rep  = st_data;
    be_calc = BE_WORD;
    case (size_n)
      SZ_BYTE: begin
        st_rep  = {4{st_data[7:0]}};
        be_calc = 4'(BE_BYTE0 << off);
      end
      SZ_HALF: begin
        st_rep  = {2{st_data[15:0]}};
        be_calc = off[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: begin
        st_rep  = st_data;
        be_calc = BE_WORD;
      end
    endcase
  end

  // Next-state and MEM/WB update
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    we_d            = we_q;
    addr_d          = addr_q;
    dwdata_d        = dwdata_q;
    be_d            = be_q;
    misalign_d      = 1'b0;
    lat_off_d       = lat_off_q;
    lat_size_d      = lat_size_q;
    lat_unsigned_d  = lat_unsigned_q;
    lat_waddr_d     = lat_waddr_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_mem_read_d  = lat_mem_read_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_waddr_d      = wb_waddr_q;
    wb_mem_read_d   = wb_mem_read_q;
    wb_wdata_d      = wb_wdata_q;
    stall_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!is_mem) begin
          wb_reg_write_d = i_EX_MEM_reg_write;
          wb_waddr_d     = i_EX_MEM_write_addr;
          wb_mem_read_d  = 1'b0;
          wb_wdata_d     = i_EX_MEM_alu_out;
        end else if (misal) begin
          misalign_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_mem_read_d  = 1'b0;
        end else begin
          stall_c         = 1'b1;
          state_d         = ST_BUSY;
          req_d           = 1'b1;
          we_d            = i_EX_MEM_mem_write;
          addr_d          = {i_EX_MEM_alu_out[31:2], 2'b00};
          be_d            = be_calc;
          dwdata_d        = st_rep;
          lat_off_d       = off;
          lat_size_d      = size_n;
          lat_unsigned_d  = i_EX_MEM_unsigned;
          lat_waddr_d     = i_EX_MEM_write_addr;
          lat_reg_write_d = i_EX_MEM_reg_write & ~i_EX_MEM_mem_write;
          // Read+write together behaves as a store
          lat_mem_read_d  = i_EX_MEM_mem_read & ~i_EX_MEM_mem_write;
          wb_reg_write_d  = 1'b0;
          wb_mem_read_d   = 1'b0;
        end
      end
      ST_BUSY: begin
        stall_c = ~i_dmem_ack;
        if (i_dmem_ack) begin
          state_d        = ST_IDLE;
          req_d          = 1'b0;
          we_d           = 1'b0;
          addr_d         = '0;
          dwdata_d       = '0;
          be_d           = '0;
          wb_reg_write_d = lat_reg_write_q;
          wb_waddr_d     = lat_waddr_q;
          wb_mem_read_d  = lat_mem_read_q;
          if (lat_mem_read_q) begin
            wb_wdata_d = load_val;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      dwdata_q        <= '0;
      be_q            <= '0;
      misalign_q      <= 1'b0;
      lat_off_q       <= '0;
      lat_size_q      <= '0;
      lat_unsigned_q  <= 1'b0;
      lat_waddr_q     <= '0;
      lat_reg_write_q <= 1'b0;
      lat_mem_read_q  <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_waddr_q      <= '0;
      wb_mem_read_q   <= 1'b0;
      wb_wdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      dwdata_q        <= dwdata_d;
      be_q            <= be_d;
      misalign_q      <= misalign_d;
      lat_off_q       <= lat_off_d;
      lat_size_q      <= lat_size_d;
      lat_unsigned_q  <= lat_unsigned_d;
      lat_waddr_q     <= lat_waddr_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_mem_read_q  <= lat_mem_read_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_waddr_q      <= wb_waddr_d;
      wb_mem_read_q   <= wb_mem_read_d;
      wb_wdata_q      <= wb_wdata_d;
    end
  end

  // Stall is held low throughout reset regardless of EX/MEM contents
  assign o_stall             = stall_c & ~i_rst;
  assign o_dmem_req          = req_q;
  assign o_dmem_we           = we_q;
  assign o_dmem_addr         = addr_q;
  assign o_dmem_wdata        = dwdata_q;
  assign o_dmem_be           = be_q;
  assign o_misalign          = misalign_q;
  assign o_MEM_WB_reg_write  = wb_reg_write_q;
  assign o_MEM_WB_write_addr = wb_waddr_q;
  assign o_MEM_WB_mem_read   = wb_mem_read_q;
  assign o_MEM_WB_Rt         = wb_waddr_q;
  assign o_MEM_WB_wdata      = wb_wdata_q;

endmodule
